disp_sched_ctrl: RTL
====================

Name: disp_sched_ctrl

Overview:
- Parametrised, synthesisable successor to the file-driven display-control scheduler.
- Holds a writable table of (display value, BCD decimal start cycle) entries.
- Counts clock cycles and drives the current display-enable value onto DispValOut when each entry's start cycle is reached.
- Adds a register-style load port, a rescan request that replaces the periodic file re-read, a repeat mode and pause/enable control. Sits beside test-bench monitors, whose debug printing it gates.

Parameters:
DISP_BITS, 32, width of display-control value
ADDR_BITS, 4, table index width; ENTRIES = 2**ADDR_BITS
TIME_DIGITS, 8, BCD digits per start time
CYCLE_BITS, 32, cycle counter and converted start-time width

Ports:
Clk  in  1  clock; all state on rising edge
Reset  in  1  asynchronous, active-high reset
Enable  in  1  run/pause control; counter and FSM advance only while high
CfgWe  in  1  table write strobe
CfgAddr  in  ADDR_BITS  table write index
CfgValid  in  1  valid bit written with entry; invalid marks end of table
CfgVal  in  DISP_BITS  display value written
CfgTime  in  TIME_DIGITS*4  BCD start cycle written, most-significant digit in top nibble
Rescan  in  1  single-cycle request to re-fetch the current entry
Repeat  in  1  1 = loop table at end
DispValOut  out  DISP_BITS  current display-control value
CycleNo  out  CYCLE_BITS  cycle count
EntryIdx  out  ADDR_BITS  index of entry being fetched or awaited
Update  out  1  one-cycle pulse when DispValOut is loaded
Done  out  1  high in DONE state

Behaviour:
- Reset (async, any state): DispValOut=0, CycleNo=0, EntryIdx=0, Update=0, Done=0, FSM=IDLE. Table contents are not reset; all valid bits are cleared.
- Table writes:
  - Accepted every cycle regardless of Enable or state.
  - A write does not affect an entry already latched by FETCH until that entry is re-fetched.
- CycleNo:
  - Increments by 1 on each Enable-high cycle in any state except IDLE.
  - Saturates at all-ones.
  - Held while Enable is low.
- FSM (advances only when Enable=1; otherwise holds state and all outputs, and Update=0):
  - IDLE: on Enable=1, go to FETCH with EntryIdx=0. Rescan is ignored.
  - FETCH (1 cycle):
    - Latches valid, value and BCD time of entry EntryIdx.
    - If invalid and Repeat=1 and EntryIdx!=0: EntryIdx=0, CycleNo=0, stay in FETCH.
    - If invalid otherwise: go to DONE.
    - Else: clear accumulator and go to CONV.
  - CONV (exactly TIME_DIGITS cycles): Horner conversion, one digit per cycle, MS digit first: acc = acc*10 + digit.
    - Nibbles >9 are weighted as their binary value, not flagged.
    - Result is truncated modulo 2**CYCLE_BITS. Then go to WAIT.
  - WAIT: each cycle compare CycleNo >= acc (unsigned). On true, at that edge:
    - DispValOut=latched value; Update=1 for one cycle.
    - EntryIdx=EntryIdx+1, wrapping to 0 after ENTRIES-1. The wrap is treated as end of table: Repeat=1 reloads with CycleNo=0; Repeat=0 goes to DONE.
    - Go to FETCH.
  - DONE: Done=1, DispValOut held. Rescan=1 goes to FETCH at the current EntryIdx, so appended entries run.
- Rescan in FETCH/CONV/WAIT: abandon current conversion/wait and go to FETCH of the same EntryIdx next cycle. DispValOut and CycleNo are unaffected.
- Precedence: Reset > Enable low > Rescan > WAIT match.
- Past-due entries (start time <= CycleNo at conversion end) apply on the first WAIT cycle. Minimum spacing between consecutive updates is TIME_DIGITS+2 cycles.
- An entry with start time 0 applies on its first WAIT cycle.

Test Plan:
1. Entries {0:(0x0A,"00000010"), 1:(0x0B,"00000025"), 2 invalid}, Enable from reset release -> DispValOut=0 until the edge where CycleNo=10, then 0x0A with Update pulse; 0x0B at CycleNo=25; Done=1 from next FETCH; CycleNo keeps counting.
2. BCD check: entry 0 time 0x00000123 -> update at CycleNo=123, not 291; time 0x0000001F -> update at 25.
3. Back-to-back: entries (0x11,"5"), (0x22,"5") -> 0x11 at CycleNo=5, 0x22 at CycleNo=15 (TIME_DIGITS+2 later).
4. Repeat=1, entries (0x1,"3"), (0x2,"6"), entry 2 invalid -> DispValOut alternates 1/2; CycleNo returns to 0 after each pass; Done stays 0.
5. Rescan: entry 1 time "100", waiting; write entry 1 time "50" at cycle 20:
   - Rescan at cycle 30 -> update at 50.
   - No Rescan -> update at 100.
   - From DONE: write entry 2 valid, pulse Rescan -> entry 2 applied.
6. Enable low for 7 cycles during WAIT -> CycleNo frozen, update delayed 7 cycles. Reset asserted mid-CONV -> outputs 0 immediately, IDLE, table invalid.

Source files
------------

// File: rtl/disp_sched_ctrl.sv
// rtl/disp_sched_ctrl.sv - display-control scheduler driven by a writable table of timed entries
// Each entry's BCD start cycle is converted serially, then its value is applied once CycleNo reaches it.
module disp_sched_ctrl #(
    parameter int DISP_BITS   = 32,
    parameter int ADDR_BITS   = 4,
    parameter int TIME_DIGITS = 8,
    parameter int CYCLE_BITS  = 32
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Enable,
    input  logic                     CfgWe,
    input  logic [ADDR_BITS-1:0]     CfgAddr,
    input  logic                     CfgValid,
    input  logic [DISP_BITS-1:0]     CfgVal,
    input  logic [TIME_DIGITS*4-1:0] CfgTime,
    input  logic                     Rescan,
    input  logic                     Repeat,
    output logic [DISP_BITS-1:0]     DispValOut,
    output logic [CYCLE_BITS-1:0]    CycleNo,
    output logic [ADDR_BITS-1:0]     EntryIdx,
    output logic                     Update,
    output logic                     Done
);

    localparam int ENTRIES   = 2**ADDR_BITS;
    localparam int TIME_BITS = TIME_DIGITS*4;
    localparam int DIG_BITS  = $clog2(TIME_DIGITS+1);

    typedef enum logic [2:0] {IDLE, FETCH, CONV, WAIT, DONE} state_t;

    state_t                 state;
    logic [DISP_BITS-1:0]   tblVal  [ENTRIES];
    logic [TIME_BITS-1:0]   tblTime [ENTRIES];
    logic [ENTRIES-1:0]     tblValid;

    logic [DISP_BITS-1:0]   curVal;
    logic [TIME_BITS-1:0]   shiftTime;
    logic [CYCLE_BITS-1:0]  acc;
    logic [DIG_BITS-1:0]    digCnt;

    logic [3:0]             digit;
    logic [CYCLE_BITS-1:0]  accNext;
    logic [CYCLE_BITS-1:0]  cycleInc;
    logic                   lastIdx;

    // Table payload is deliberately left unreset; only the valid bits define table contents.
    always_ff @(posedge Clk) begin
        if (CfgWe) begin
            tblVal[CfgAddr]  <= CfgVal;
            tblTime[CfgAddr] <= CfgTime;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tblValid <= '0;
        end else if (CfgWe) begin
            tblValid[CfgAddr] <= CfgValid;
        end
    end

    always_comb begin
        digit    = shiftTime[TIME_BITS-1 -: 4];
        accNext  = (acc << 3) + (acc << 1) + CYCLE_BITS'(digit);
        cycleInc = (CycleNo == '1) ? CycleNo : CycleNo + 1'b1;
        lastIdx  = (EntryIdx == ADDR_BITS'(ENTRIES-1));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            DispValOut <= '0;
            CycleNo    <= '0;
            EntryIdx   <= '0;
            Update     <= 1'b0;
            Done       <= 1'b0;
            curVal     <= '0;
            shiftTime  <= '0;
            acc        <= '0;
            digCnt     <= '0;
        end else begin
            Update <= 1'b0;
            if (Enable) begin
                if (state != IDLE) begin
                    CycleNo <= cycleInc;
                end
                case (state)
                    IDLE: begin
                        state    <= FETCH;
                        EntryIdx <= '0;
                    end
                    FETCH: begin
                        if (!Rescan) begin
                            if (!tblValid[EntryIdx]) begin
                                if (Repeat && EntryIdx != '0) begin
                                    EntryIdx <= '0;
                                    CycleNo  <= '0;
                                end else begin
                                    state <= DONE;
                                    Done  <= 1'b1;
                                end
                            end else begin
                                curVal    <= tblVal[EntryIdx];
                                shiftTime <= tblTime[EntryIdx];
                                acc       <= '0;
                                digCnt    <= '0;
                                state     <= CONV;
                            end
                        end
                    end
                    CONV: begin
                        if (Rescan) begin
                            state <= FETCH;
                        end else begin
                            acc       <= accNext;
                            shiftTime <= shiftTime << 4;
                            digCnt    <= digCnt + 1'b1;
                            if (digCnt == DIG_BITS'(TIME_DIGITS-1)) begin
                                state <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        if (Rescan) begin
                            state <= FETCH;
                        end else if (CycleNo >= acc) begin
                            DispValOut <= curVal;
                            Update     <= 1'b1;
                            state      <= FETCH;
                            // Index wrap counts as end of table.
                            if (lastIdx) begin
                                EntryIdx <= '0;
                                if (Repeat) begin
                                    CycleNo <= '0;
                                end else begin
                                    state <= DONE;
                                    Done  <= 1'b1;
                                end
                            end else begin
                                EntryIdx <= EntryIdx + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (Rescan) begin
                            state <= FETCH;
                            Done  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
